gpio_ctrl: RTL and testbench

GPIO_CTRL -- requirements
Module: gpio_ctrl

---
 rtl/gpio_pkg.sv | 47 ++++
 rtl/gpio_in_filter.sv | 61 ++++++
 rtl/gpio_ctrl.sv | 104 ++++++++++
 tb/tb_gpio_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared register map and IRQ_EDGE encoding for the GPIO controller.
// Also provides the address-offset decode used by gpio_ctrl.
package gpio_pkg;

    localparam logic [31:0] OFF_DATA_IN  = 32'h00;
    localparam logic [31:0] OFF_DATA_OUT = 32'h04;
    localparam logic [31:0] OFF_DIR      = 32'h08;
    localparam logic [31:0] OFF_OUT_SET  = 32'h0C;
    localparam logic [31:0] OFF_OUT_CLR  = 32'h10;
    localparam logic [31:0] OFF_OUT_TGL  = 32'h14;
    localparam logic [31:0] OFF_IRQ_EN   = 32'h18;
    localparam logic [31:0] OFF_IRQ_EDGE = 32'h1C;
    localparam logic [31:0] OFF_IRQ_PEND = 32'h20;

    localparam logic EDGE_FALLING = 1'b0;
    localparam logic EDGE_RISING  = 1'b1;

    typedef enum logic [3:0] {
        REG_NONE,
        REG_DATA_IN,
        REG_DATA_OUT,
        REG_DIR,
        REG_OUT_SET,
        REG_OUT_CLR,
        REG_OUT_TGL,
        REG_IRQ_EN,
        REG_IRQ_EDGE,
        REG_IRQ_PEND
    } reg_sel_e;

    // Offset is the full 32-bit distance from BASE, so any stray high bit decodes to REG_NONE.
    function automatic reg_sel_e decode(input logic [31:0] offset);
        case (offset)
            OFF_DATA_IN:  return REG_DATA_IN;
            OFF_DATA_OUT: return REG_DATA_OUT;
            OFF_DIR:      return REG_DIR;
            OFF_OUT_SET:  return REG_OUT_SET;
            OFF_OUT_CLR:  return REG_OUT_CLR;
            OFF_OUT_TGL:  return REG_OUT_TGL;
            OFF_IRQ_EN:   return REG_IRQ_EN;
            OFF_IRQ_EDGE: return REG_IRQ_EDGE;
            OFF_IRQ_PEND: return REG_IRQ_PEND;
            default:      return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/gpio_in_filter.sv
// Per-bit two-flop synchronizer for the GPIO pins, followed by an optional
// stability filter compiled in with `define GPIO_DEBOUNCE_EN.
module gpio_in_filter #(
    parameter int W               = 32,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] pins,
    output logic [W-1:0] filtered
);

    if (W < 1 || W > 32 || DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_param
        $error("gpio_in_filter: W or DEBOUNCE_CYCLES out of range");
    end

    logic [W-1:0] sync_q1;
    logic [W-1:0] sync_q2;

    // NOTE: non-blocking assignments on every flop, so each stage sees the pre-edge value of the one before.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= pins;
            sync_q2 <= sync_q1;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam logic [15:0] LAST_COUNT = 16'(DEBOUNCE_CYCLES - 1);

    logic [15:0]  count [W];
    logic [W-1:0] stable;

    // NOTE: the counter array is reset explicitly so rst discards any partial count.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable <= '0;
            for (int i = 0; i < W; i++) count[i] <= '0;
        end else begin
            for (int i = 0; i < W; i++) begin
                if (sync_q2[i] == stable[i]) begin
                    count[i] <= '0;
                end else if (count[i] == LAST_COUNT) begin
                    stable[i] <= sync_q2[i];
                    count[i]  <= '0;
                end else begin
                    count[i] <= count[i] + 16'd1;
                end
            end
        end
    end

    assign filtered = stable;
`else
    assign filtered = sync_q2;
`endif

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO block: output/direction registers, set/clear/toggle
// aliases and edge interrupts; debounce is enabled with `define GPIO_DEBOUNCE_EN.
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int          W               = 32,
    parameter logic [31:0] BASE            = 32'hA000_0000,
    parameter int          DEBOUNCE_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  address,
    input  logic [31:0]  write_data,
    input  logic         write_enable,
    output logic [31:0]  read_data,
    input  logic [W-1:0] gpio_in,
    output logic [W-1:0] gpio_out,
    output logic [W-1:0] gpio_oe,
    output logic         irq
);

    reg_sel_e     sel;
    logic [W-1:0] wdata;
    logic [W-1:0] filtered;
    logic [W-1:0] filtered_prev;
    logic [W-1:0] edge_hit;
    logic [W-1:0] clr_mask;

    logic [W-1:0] data_out;
    logic [W-1:0] dir;
    logic [W-1:0] irq_en;
    logic [W-1:0] irq_edge;
    logic [W-1:0] irq_pend;

    assign sel   = decode(address - BASE);
    assign wdata = write_data[W-1:0];

    gpio_in_filter #(
        .W               (W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_in_filter (
        .clk      (clk),
        .rst      (rst),
        .pins     (gpio_in),
        .filtered (filtered)
    );

    always_comb begin
        for (int i = 0; i < W; i++) begin
            edge_hit[i] = (irq_edge[i] == EDGE_RISING) ? (filtered[i] & ~filtered_prev[i])
                                                       : (~filtered[i] & filtered_prev[i]);
        end
    end

    assign clr_mask = (write_enable && sel == REG_IRQ_PEND) ? wdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out      <= '0;
            dir           <= '0;
            irq_en        <= '0;
            irq_edge      <= '0;
            irq_pend      <= '0;
            filtered_prev <= '0;
            gpio_out      <= '0;
            gpio_oe       <= '0;
        end else begin
            filtered_prev <= filtered;
            gpio_out      <= data_out;
            gpio_oe       <= dir;
            // A new edge is OR-ed in after the clear, so it wins over a coincident W1C.
            irq_pend      <= (irq_pend & ~clr_mask) | edge_hit;
            if (write_enable) begin
                case (sel)
                    REG_DATA_OUT: data_out <= wdata;
                    REG_DIR:      dir      <= wdata;
                    REG_OUT_SET:  data_out <= data_out | wdata;
                    REG_OUT_CLR:  data_out <= data_out & ~wdata;
                    REG_OUT_TGL:  data_out <= data_out ^ wdata;
                    REG_IRQ_EN:   irq_en   <= wdata;
                    REG_IRQ_EDGE: irq_edge <= wdata;
                    default:      ;
                endcase
            end
        end
    end

    // NOTE: read_data gets its default first, so no path through the case infers a latch.
    always_comb begin
        read_data = '0;
        case (sel)
            REG_DATA_IN:  read_data[W-1:0] = filtered;
            REG_DATA_OUT: read_data[W-1:0] = data_out;
            REG_DIR:      read_data[W-1:0] = dir;
            REG_IRQ_EN:   read_data[W-1:0] = irq_en;
            REG_IRQ_EDGE: read_data[W-1:0] = irq_edge;
            REG_IRQ_PEND: read_data[W-1:0] = irq_pend;
            default:      ;
        endcase
    end

    assign irq = |(irq_pend & irq_en);

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl (W=8): directed register/IRQ/reset scenarios,
// then randomized traffic scored against a pin-history reference model.
module tb_gpio_ctrl;

    localparam int          W    = 8;
    localparam logic [31:0] BASE = 32'hA000_0000;
`ifdef GPIO_DEBOUNCE_EN
    localparam int DB      = 4;
    localparam int DIN_LAT = 2 + DB;
`else
    localparam int DB      = 16;
    localparam int DIN_LAT = 2;
`endif
    localparam int PEND_LAT = DIN_LAT + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  address;
    logic [31:0]  write_data;
    logic         write_enable;
    logic [31:0]  read_data;
    logic [W-1:0] gpio_in;
    logic [W-1:0] gpio_out;
    logic [W-1:0] gpio_oe;
    logic         irq;

    int checks = 0;
    int errors = 0;

    gpio_ctrl #(
        .W               (W),
        .BASE            (BASE),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .address      (address),
        .write_data   (write_data),
        .write_enable (write_enable),
        .read_data    (read_data),
        .gpio_in      (gpio_in),
        .gpio_out     (gpio_out),
        .gpio_oe      (gpio_oe),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "timeout");
    end

    // Reference model: register contents plus a history of sampled pin values (index 0 = newest).
    logic [W-1:0] m_data_out, m_dir, m_en, m_edge, m_pend, m_gout, m_goe;
    logic [W-1:0] hist[$];

    logic [31:0] offs [12] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14,
                               32'h18, 32'h1C, 32'h20, 32'h24, 32'h40, 32'hFFFC};

    function automatic logic [31:0] m_read(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        case (off)
            32'h00:  return 32'(hist[1]);
            32'h04:  return 32'(m_data_out);
            32'h08:  return 32'(m_dir);
            32'h18:  return 32'(m_en);
            32'h1C:  return 32'(m_edge);
            32'h20:  return 32'(m_pend);
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_edge(input logic r, input logic we, input logic [31:0] a,
                              input logic [31:0] wd, input logic [W-1:0] pin);
        logic [W-1:0] now_v, before_v, rise, fall, set, clr, d;
        if (r) begin
            m_data_out = '0; m_dir = '0; m_en = '0; m_edge = '0; m_pend = '0;
            m_gout = '0; m_goe = '0;
            hist.delete();
            repeat (4) hist.push_back('0);
            return;
        end
        now_v    = hist[1];
        before_v = hist[2];
        rise     = now_v & ~before_v;
        fall     = before_v & ~now_v;
        set      = (m_edge & rise) | (~m_edge & fall);
        m_gout   = m_data_out;
        m_goe    = m_dir;
        clr      = '0;
        d        = wd[W-1:0];
        if (we) begin
            case (a - BASE)
                32'h04: m_data_out = d;
                32'h08: m_dir      = d;
                32'h0C: m_data_out = m_data_out | d;
                32'h10: m_data_out = m_data_out & ~d;
                32'h14: m_data_out = m_data_out ^ d;
                32'h18: m_en       = d;
                32'h1C: m_edge     = d;
                32'h20: clr        = d;
                default: ;
            endcase
        end
        m_pend = (m_pend & ~clr) | set;
        hist.push_front(pin);
        void'(hist.pop_back());
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic r, we;
        logic [31:0] a, wd;
        logic [W-1:0] p;
        r = rst; we = write_enable; a = address; wd = write_data; p = gpio_in;
        @(posedge clk);
        #1;
        model_edge(r, we, a, wd, p);
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] data);
        address      = BASE + off;
        write_data   = data;
        write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [31:0] off, input logic [31:0] exp);
        write_enable = 1'b0;
        address      = BASE + off;
        #1;
        check(tag, read_data, exp);
    endtask

    initial begin
        logic [31:0] raddr;
        hist.delete();
        repeat (4) hist.push_back('0);
        rst = 1'b1; write_enable = 1'b0; address = BASE; write_data = '0; gpio_in = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_gpio_out", 32'(gpio_out), 32'h0);
        check("rst_gpio_oe", 32'(gpio_oe), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        for (int i = 0; i < 9; i++) begin
            check_reg($sformatf("rst_reg_%02h", offs[i]), offs[i], 32'h0);
            tick();
        end

        // Set/clear/toggle sequence on consecutive cycles
        wr(32'h04, 32'hA5);
        check_reg("dout_write", 32'h04, 32'hA5);
        check("gout_before", 32'(gpio_out), 32'h00);
        wr(32'h0C, 32'h0A);
        check_reg("dout_set", 32'h04, 32'hAF);
        check("gout_a5", 32'(gpio_out), 32'hA5);
        wr(32'h10, 32'h81);
        check_reg("dout_clr", 32'h04, 32'h2E);
        check("gout_af", 32'(gpio_out), 32'hAF);
        wr(32'h14, 32'hFF);
        check_reg("dout_tgl", 32'h04, 32'hD1);
        check("gout_2e", 32'(gpio_out), 32'h2E);
        tick();
        check("gout_d1", 32'(gpio_out), 32'hD1);

        // Direction with upper write bits driven, unmapped and write-only reads
        wr(32'h08, 32'h1000_00FF);
        check_reg("dir_read", 32'h08, 32'h0000_00FF);
        check("oe_same_cycle", 32'(gpio_oe), 32'h00);
        tick();
        check("oe_next_cycle", 32'(gpio_oe), 32'hFF);
        check_reg("unmapped_40", 32'h40, 32'h0);
        check_reg("wo_out_set", 32'h0C, 32'h0);
        wr(32'h40, 32'h00);
        address = (BASE + 32'h04) ^ 32'h0100_0000; write_data = 32'h00; write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
        check_reg("unmapped_write", 32'h04, 32'hD1);

        // Rising-edge interrupt on pin 0
        wr(32'h18, 32'h01);
        wr(32'h1C, 32'h01);
        gpio_in[0] = 1'b1;
        repeat (DIN_LAT - 1) tick();
        check_reg("din_early", 32'h00, 32'h00);
        tick();
        check_reg("din_pin0", 32'h00, 32'h01);
        check_reg("pend_early", 32'h20, 32'h00);
        check("irq_early", 32'(irq), 32'h0);
        tick();
        check_reg("pend_pin0", 32'h20, 32'h01);
        check("irq_set", 32'(irq), 32'h1);
        wr(32'h20, 32'h01);
        check_reg("pend_w1c", 32'h20, 32'h00);
        check("irq_w1c", 32'(irq), 32'h0);
        gpio_in[0] = 1'b0;
        repeat (PEND_LAT + 2) tick();
        check_reg("din_fall", 32'h00, 32'h00);
        check_reg("pend_fall_none", 32'h20, 32'h00);

        // Edge on pin 3 coinciding with a W1C of that bit
        wr(32'h1C, 32'h09);
        gpio_in[3] = 1'b1;
        repeat (PEND_LAT - 1) tick();
        check_reg("pend3_before", 32'h20, 32'h00);
        wr(32'h20, 32'h08);
        check_reg("pend3_set_wins", 32'h20, 32'h08);
        check("irq_masked", 32'(irq), 32'h0);
        wr(32'h1C, 32'h00);
        tick();
        check_reg("edge_change_keeps", 32'h20, 32'h08);

`ifdef GPIO_DEBOUNCE_EN
        // Short glitch is rejected, a stable change is accepted
        gpio_in[1] = 1'b1;
        repeat (3) tick();
        gpio_in[1] = 1'b0;
        repeat (10) tick();
        check_reg("glitch_din", 32'h00, 32'h08);
        check_reg("glitch_pend", 32'h20, 32'h08);
        gpio_in[1] = 1'b1;
        repeat (DIN_LAT) tick();
        check_reg("stable_din", 32'h00, 32'h0A);
        gpio_in[1] = 1'b0;
        repeat (DIN_LAT + 2) tick();
`endif

        // Reset in the middle of a pending pin change
        wr(32'h04, 32'hFF);
        wr(32'h18, 32'h08);
        check("irq_before_rst", 32'(irq), 32'h1);
        gpio_in = 8'h0A;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_gpio_out", 32'(gpio_out), 32'h0);
        check("rst2_gpio_oe", 32'(gpio_oe), 32'h0);
        check("rst2_irq", 32'(irq), 32'h0);
        check_reg("rst2_din", 32'h00, 32'h0);
        check_reg("rst2_dout", 32'h04, 32'h0);
        check_reg("rst2_dir", 32'h08, 32'h0);
        repeat (DIN_LAT - 1) tick();
        check_reg("rst2_din_late", 32'h00, 32'h0);
        check_reg("rst2_en", 32'h18, 32'h0);
        tick();
        check_reg("rst2_din_new", 32'h00, 32'h0A);
        check_reg("rst2_edge", 32'h1C, 32'h0);
        check_reg("rst2_pend", 32'h20, 32'h0);

        // Randomized traffic against the model, from a fresh reset
        gpio_in = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int n = 0; n < 400; n++) begin
            address = BASE + offs[$urandom_range(0, 11)];
            if ($urandom_range(0, 7) == 0) address = address ^ 32'h0100_0000;
            write_enable = 1'($urandom_range(0, 1));
            write_data   = $urandom;
`ifndef GPIO_DEBOUNCE_EN
            if ($urandom_range(0, 2) == 0) gpio_in = gpio_in ^ W'(1 << $urandom_range(0, W - 1));
`endif
            tick();
            write_enable = 1'b0;
            check("rnd_gpio_out", 32'(gpio_out), 32'(m_gout));
            check("rnd_gpio_oe", 32'(gpio_oe), 32'(m_goe));
            check("rnd_irq", 32'(irq), 32'(|(m_pend & m_en)));
            raddr   = BASE + offs[$urandom_range(0, 11)];
            address = raddr;
            #1;
            check($sformatf("rnd_read_%08h", raddr), read_data, m_read(raddr));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
